// File: rtl/nios_mul_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : nios_mul_pipe_if
// Description : Operand/result handshake bundle for nios_mul_pipe.
//               out_ovf exists only when NIOS_MUL_PIPE_SAT_STATUS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface nios_mul_pipe_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_src1;
  logic [DATA_W-1:0] in_src2;
  logic              in_src1_signed;
  logic              in_src2_signed;
  logic              in_high;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [TAG_W-1:0]  out_tag;
  logic              busy;
`ifdef NIOS_MUL_PIPE_SAT_STATUS_EN
  logic              out_ovf;

  modport master (
    output in_valid, in_src1, in_src2, in_src1_signed, in_src2_signed, in_high, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, busy, out_ovf
  );
  modport slave (
    input  in_valid, in_src1, in_src2, in_src1_signed, in_src2_signed, in_high, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy, out_ovf
  );
`else
  modport master (
    output in_valid, in_src1, in_src2, in_src1_signed, in_src2_signed, in_high, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, busy
  );
  modport slave (
    input  in_valid, in_src1, in_src2, in_src1_signed, in_src2_signed, in_high, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy
  );
`endif
endinterface
`default_nettype wire

// File: rtl/nios_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : nios_mul_pipe
// Description : Pipelined signed/unsigned DATA_W x DATA_W multiplier with
//               high/low half select, tag sideband and full backpressure.
//               Optional overflow flag: NIOS_MUL_PIPE_SAT_STATUS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nios_mul_pipe #(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  wire logic      clk,
  input  wire logic      reset,
  nios_mul_pipe_if.slave bus
);

  localparam int c_ext_w  = DATA_W + 1;
  localparam int c_prod_w = 2 * DATA_W;
  localparam int c_half_w = DATA_W / 2;
  localparam int c_opq    = (PIPE_STAGES >= 3) ? PIPE_STAGES - 2 : 1;

  logic w_adv;
  assign w_adv        = ~(bus.out_valid & ~bus.out_ready);
  assign bus.in_ready = w_adv;

  logic signed [c_ext_w-1:0] w_a_ext;
  logic signed [c_ext_w-1:0] w_b_ext;
  assign w_a_ext = {bus.in_src1_signed & bus.in_src1[DATA_W-1], bus.in_src1};
  assign w_b_ext = {bus.in_src2_signed & bus.in_src2[DATA_W-1], bus.in_src2};

  // Valid and tag travel through every stage; bubbles advance like real ops.
  logic [PIPE_STAGES-1:0] r_vld;
  logic [TAG_W-1:0]       r_tag [PIPE_STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) r_tag[i] <= '0;
    end else if (w_adv) begin
      r_vld[0] <= bus.in_valid;
      r_tag[0] <= bus.in_tag;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign bus.out_valid = r_vld[PIPE_STAGES-1];
  assign bus.out_tag   = r_tag[PIPE_STAGES-1];
  assign bus.busy      = |r_vld;

  // Full product and mode of the operation about to enter the output register.
  logic [c_prod_w-1:0] w_prod;
  logic                w_fin_high;
`ifdef NIOS_MUL_PIPE_SAT_STATUS_EN
  logic                w_fin_sgn;
`endif

  generate
    if (PIPE_STAGES == 1) begin : g_single
      logic signed [c_prod_w-1:0] w_a_f;
      logic signed [c_prod_w-1:0] w_b_f;
      assign w_a_f      = w_a_ext;
      assign w_b_f      = w_b_ext;
      assign w_prod     = w_a_f * w_b_f;
      assign w_fin_high = bus.in_high;
`ifdef NIOS_MUL_PIPE_SAT_STATUS_EN
      assign w_fin_sgn  = bus.in_src1_signed | bus.in_src2_signed;
`endif
    end else begin : g_multi
      localparam int c_ctl = PIPE_STAGES - 1;
      logic signed [c_ext_w-1:0] r_a [c_opq];
      logic signed [c_ext_w-1:0] r_b [c_opq];
      logic [c_ctl-1:0]          r_high;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_high <= '0;
          for (int i = 0; i < c_opq; i++) begin
            r_a[i] <= '0;
            r_b[i] <= '0;
          end
        end else if (w_adv) begin
          r_a[0]    <= w_a_ext;
          r_b[0]    <= w_b_ext;
          r_high[0] <= bus.in_high;
          for (int i = 1; i < c_opq; i++) begin
            r_a[i] <= r_a[i-1];
            r_b[i] <= r_b[i-1];
          end
          for (int i = 1; i < c_ctl; i++) r_high[i] <= r_high[i-1];
        end
      end
      assign w_fin_high = r_high[c_ctl-1];

`ifdef NIOS_MUL_PIPE_SAT_STATUS_EN
      logic [c_ctl-1:0] r_sgn;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_sgn <= '0;
        end else if (w_adv) begin
          r_sgn[0] <= bus.in_src1_signed | bus.in_src2_signed;
          for (int i = 1; i < c_ctl; i++) r_sgn[i] <= r_sgn[i-1];
        end
      end
      assign w_fin_sgn = r_sgn[c_ctl-1];
`endif

      if (PIPE_STAGES == 2) begin : g_direct
        logic signed [c_prod_w-1:0] w_a_f;
        logic signed [c_prod_w-1:0] w_b_f;
        assign w_a_f  = r_a[0];
        assign w_b_f  = r_b[0];
        assign w_prod = w_a_f * w_b_f;
      end else begin : g_split
        // B = B_hi * 2^half + B_lo, with B_hi signed and B_lo unsigned.
        logic signed [c_prod_w-1:0] w_a_f;
        logic signed [c_prod_w-1:0] w_blo_f;
        logic signed [c_prod_w-1:0] w_bhi_f;
        logic signed [c_prod_w-1:0] r_pp_lo;
        logic signed [c_prod_w-1:0] r_pp_hi;
        assign w_a_f   = r_a[c_opq-1];
        assign w_blo_f = {{(c_prod_w-c_half_w){1'b0}}, r_b[c_opq-1][c_half_w-1:0]};
        assign w_bhi_f = $signed(r_b[c_opq-1][c_ext_w-1:c_half_w]);

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            r_pp_lo <= '0;
            r_pp_hi <= '0;
          end else if (w_adv) begin
            r_pp_lo <= w_a_f * w_blo_f;
            r_pp_hi <= w_a_f * w_bhi_f;
          end
        end
        assign w_prod = (r_pp_hi << c_half_w) + r_pp_lo;
      end
    end
  endgenerate

  logic [DATA_W-1:0] w_res;
  logic [DATA_W-1:0] r_res;
  assign w_res = w_fin_high ? w_prod[c_prod_w-1:DATA_W] : w_prod[DATA_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_res <= '0;
    else if (w_adv) r_res <= w_res;
  end
  assign bus.out_result = r_res;

`ifdef NIOS_MUL_PIPE_SAT_STATUS_EN
  // Signed fit: bits [2W-1:W-1] all equal. Unsigned fit: bits [2W-1:W] zero.
  logic w_ovf;
  logic r_ovf;
  assign w_ovf = ~w_fin_high &
                 (w_fin_sgn ? ~((&w_prod[c_prod_w-1:DATA_W-1]) | ~(|w_prod[c_prod_w-1:DATA_W-1]))
                            : (|w_prod[c_prod_w-1:DATA_W]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_ovf <= 1'b0;
    else if (w_adv) r_ovf <= w_ovf;
  end
  assign bus.out_ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nios_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios_mul_pipe
// Description : Scoreboard bench for nios_mul_pipe (directed + random traffic).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nios_mul_pipe;
  localparam int DW = 32;
  localparam int PS = 2;
  localparam int TW = 5;
  localparam longint LIM = 64'sd1 <<< (DW - 1);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  nios_mul_pipe_if #(.DATA_W(DW), .TAG_W(TW)) bus ();
  nios_mul_pipe #(.DATA_W(DW), .PIPE_STAGES(PS), .TAG_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
    logic          ovf;
  } exp_t;

  exp_t exp_q [$];
  int   checks   = 0;
  int   failures = 0;
  int   run_len  = 0;
  int   max_run  = 0;
  bit   rnd_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: operands as mathematical integers, exact product, then truncate.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic sa, input logic sb, input logic hi,
                                 input logic [TW-1:0] tag);
    logic signed [127:0] va, vb, p;
    longint              pt;
    longint unsigned     ptu;
    exp_t                e;
    va = sa ? $signed(a) : $signed({1'b0, a});
    vb = sb ? $signed(b) : $signed({1'b0, b});
    p  = va * vb;
    pt  = p[63:0];
    ptu = p[63:0];
    e.res = hi ? p[2*DW-1:DW] : p[DW-1:0];
    e.tag = tag;
    if (hi)            e.ovf = 1'b0;
    else if (sa || sb) e.ovf = (pt < -LIM) || (pt >= LIM);
    else               e.ovf = (ptu >= 64'h1_0000_0000);
    return e;
  endfunction

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic sa, input logic sb, input logic hi, input logic [TW-1:0] tag);
    bit done = 0;
    bus.in_valid       = 1'b1;
    bus.in_src1        = a;
    bus.in_src2        = b;
    bus.in_src1_signed = sa;
    bus.in_src2_signed = sb;
    bus.in_high        = hi;
    bus.in_tag         = tag;
    for (int w = 0; w < 60 && !done; w++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(model(a, b, sa, sb, hi, tag));
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stayed 0 for tag %0d", tag);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_expect(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic sa, input logic sb, input logic hi,
                             input logic [TW-1:0] tag, input logic [DW-1:0] want, input string name);
    int n = 0;
    send(a, b, sa, sb, hi, tag);
    while (!bus.out_valid && n < 10) begin @(posedge clk); #1; n++; end
    check(name, bus.out_result, want);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    check("drain_queue", exp_q.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  function automatic logic [DW-1:0] rnd_op();
    case ($urandom % 5)
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000 | ($urandom % 4);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      check("in_ready_rule", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      run_len = bus.out_valid ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out: out_valid=1 tag=%0d result=0x%0h with nothing expected",
                   bus.out_tag, bus.out_result);
        end else begin
          check("out_result", bus.out_result, exp_q[0].res);
          check("out_tag", bus.out_tag, exp_q[0].tag);
`ifdef NIOS_MUL_PIPE_SAT_STATUS_EN
          check("out_ovf", bus.out_ovf, exp_q[0].ovf);
`endif
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus.in_valid = 0; bus.in_src1 = '0; bus.in_src2 = '0;
    bus.in_src1_signed = 0; bus.in_src2_signed = 0; bus.in_high = 0; bus.in_tag = '0;
    bus.out_ready = 1;
    repeat (2) @(posedge clk); #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_result", bus.out_result, 0);
    check("rst_out_tag", bus.out_tag, 0);
    reset = 0;
    @(posedge clk); #1;

    // Latency and basic low/high halves
    send(32'h0001_0003, 32'h0002_0005, 0, 0, 0, 7);
    lat = 0;
    while (!bus.out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    check("latency_edges", lat, PS - 1);
    check("t1_result", bus.out_result, 32'h000B_000F);
    check("t1_tag", bus.out_tag, 7);
    repeat (2) begin @(posedge clk); #1; end
    send_expect(32'h0001_0003, 32'h0002_0005, 0, 0, 1, 8, 32'h0000_0002, "t2_high");
    send_expect('1, '1, 0, 0, 1, 1, 32'hFFFF_FFFE, "ff_uu_high");
    send_expect('1, '1, 1, 1, 1, 2, 32'h0000_0000, "ff_ss_high");
    send_expect('1, '1, 1, 0, 1, 3, 32'hFFFF_FFFF, "ff_su_high");
    send_expect('1, '1, 1, 1, 0, 4, 32'h0000_0001, "ff_ss_low");
    send_expect('1, '1, 1, 0, 0, 5, 32'h0000_0001, "ff_su_low");
`ifdef NIOS_MUL_PIPE_SAT_STATUS_EN
    send_expect(32'h0001_0000, 32'h0001_0000, 0, 0, 0, 9, 32'h0, "ovf_big_low");
    send(32'd3, 32'd5, 0, 0, 0, 10);
    check("ovf_small", bus.out_ovf, 0);
    @(posedge clk); #1;
    check("ovf_small_result", bus.out_result, 32'd15);
`endif
    drain();
    check("idle_busy", bus.busy, 0);

    // Back-to-back burst of 8
    max_run = 0;
    for (int i = 0; i < 8; i++)
      send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'($urandom), TW'(i));
    drain();
    check("burst_run", max_run, 8);

    // Backpressure: hold out_ready low for 3 stalled cycles
    bus.out_ready = 0;
    fork
      begin
        send(32'h1234_5678, 32'h0000_0010, 0, 0, 0, 20);
        send(32'hFFFF_FFF0, 32'h0000_0003, 1, 0, 0, 21);
        send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 1, 1, 22);
      end
      begin
        int n = 0;
        while (!bus.out_valid && n < 10) begin @(posedge clk); #1; n++; end
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", bus.in_ready, 0);
          check("bp_busy", bus.busy, 1);
          check("bp_tag_hold", bus.out_tag, 20);
          check("bp_result_hold", bus.out_result, 32'h2345_6780);
        end
        @(posedge clk); #1;
        bus.out_ready = 1;
      end
    join
    drain();

    // Reset with two operations in flight
    bus.out_ready = 0;
    send(32'd100, 32'd200, 0, 0, 0, 10);
    send(32'd300, 32'd400, 0, 0, 0, 11);
    #1 reset = 1;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_out_tag", bus.out_tag, 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 0;
    bus.out_ready = 1;
    repeat (6) begin @(posedge clk); #1; end
    check("post_rst_out_valid", bus.out_valid, 0);

    // Random traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 60; i++)
          send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'($urandom), TW'(i));
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom % 4) != 0;
        end
      end
    join
    bus.out_ready = 1;
    drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nios_mul_pipe.md
Name: nios_mul_pipe

Overview:
- Parametrised, pipelined integer multiply unit for the Nios II-class datapath. Generalises the fixed 32x32 low-word multiply cell.
- Adds:
  - configurable operand width and pipeline depth
  - per-operand signedness
  - high/low product-half select (mul, mulxss, mulxsu, mulxuu)
  - valid/ready handshake with full backpressure
  - a sideband tag carried alongside each operation
- Sits between the execute-stage operand muxes and the writeback result mux.

Parameters:
- DATA_W, 32, operand width in bits; legal values 8..64, multiple of 8.
- PIPE_STAGES, 2, register stages from input accept to out_valid; legal values 1..4.
- TAG_W, 5, width of the sideband tag (destination register index) passed through unchanged.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-high reset.
- in_valid, input, 1, operation presented this cycle.
- in_ready, output, 1, unit can accept an operation this cycle.
- in_src1, input, DATA_W, operand A.
- in_src2, input, DATA_W, operand B.
- in_src1_signed, input, 1, 1 = treat in_src1 as two's complement.
- in_src2_signed, input, 1, 1 = treat in_src2 as two's complement.
- in_high, input, 1, 1 = return product bits [2*DATA_W-1:DATA_W]; 0 = return bits [DATA_W-1:0].
- in_tag, input, TAG_W, sideband tag.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer accepts the result.
- out_result, output, DATA_W, selected product half.
- out_tag, output, TAG_W, tag of the returned operation.
- busy, output, 1, at least one stage holds a valid operation.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: all stage valid bits clear immediately.
  - out_valid=0, busy=0, in_ready=1.
  - out_result and out_tag read 0.
  - Data registers are also cleared.
- Reset mid-operation: in-flight operations are discarded. No result appears after reset deasserts.
- Handshake:
  - Accept occurs when in_valid & in_ready.
  - Result transfer occurs when out_valid & out_ready.
- Stall rule:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall. It is combinational from out_valid/out_ready and independent of in_valid.
- Stall semantics:
  - During stall every stage register holds, including out_result and out_tag.
  - Stage valid bits are not overwritten.
- Bubbles: when not stalled, each stage advances every cycle, including empty stages.
- Latency: an operation accepted at edge N produces out_valid=1 after edge N+PIPE_STAGES-1. The output is the last stage register.
- Throughput: one operation per cycle with out_ready held high.
- Ordering: strict FIFO. out_tag always matches the operation whose result is on out_result.
- Arithmetic:
  - Each operand is extended to DATA_W+1 bits: sign-extended when its signed flag is 1, zero-extended otherwise.
  - The signed (DATA_W+1)x(DATA_W+1) product is truncated to 2*DATA_W bits.
  - in_high selects the half.
  - Mode bits and tag are registered with the operands and travel through every stage.
- Stage mapping:
  - Stage 1 registers the extended operands and mode.
  - The multiply is placed before the final stage.
  - With PIPE_STAGES>=3 the product is split into DATA_W/2-wide partial products summed in the following stage.
  - Extra stages beyond 3 are retiming-only delay stages.
  - With PIPE_STAGES=1 the multiply is combinational into the single output register.
- busy is the OR of all stage valid bits, registered.
- Simultaneous accept and drain in the same cycle is legal. The pipeline shifts and stays full.
- in_valid while in_ready=0: inputs are ignored. The source must hold them until accepted.

Optional Feature:
- Macro: NIOS_MUL_PIPE_SAT_STATUS_EN
- When defined:
  - Adds output out_ovf (1 bit, registered and stalled like out_result).
  - out_ovf=1 when in_high=0 and the 2*DATA_W product is not representable in DATA_W bits: signed range if either operand is signed, unsigned range otherwise.
  - out_ovf is 0 when in_high=1 and is reset to 0.
- When undefined: the port and its logic are absent. Latency and behaviour are otherwise identical.

Test Plan:
- Reset with DATA_W=32, PIPE_STAGES=2, out_ready=1: src1=0x00010003, src2=0x00020005, unsigned, high=0, tag=7 -> out_valid high exactly 1 cycle after accept; out_result=0x000B000F; out_tag=7.
- Same operands with high=1 -> out_result=0x00000002.
- src1=src2=0xFFFFFFFF, high=1: uu -> 0xFFFFFFFE; ss -> 0x00000000; su (src1 signed) -> 0xFFFFFFFF. The ss and su cases also return 0x00000001 with high=0.
- Back-to-back 8 operations with out_ready=1 -> 8 consecutive out_valid cycles, results in order, tags 0..7.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0; out_result/out_tag stable; no loss or duplication after release.
- Assert reset mid-stream with 2 operations in flight -> out_valid=0 and busy=0 immediately. No stale result after deassert.
- With NIOS_MUL_PIPE_SAT_STATUS_EN: 0x00010000*0x00010000, unsigned, low -> out_ovf=1. 3*5, low -> out_ovf=0.
